// File: rtl/video_csr_pkg.sv
// Shared definitions for the video core CSR block: register map, CTRL bit
// positions and the shadow-to-active commit state machine encoding.
package video_csr_pkg;

  localparam int unsigned CSR_CTRL   = 0;
  localparam int unsigned CSR_PARAM  = 1;
  localparam int unsigned CSR_STATUS = 2;
  localparam int unsigned CSR_ID     = 3;

  localparam int unsigned CTRL_BYPASS_BIT  = 0;
  localparam int unsigned CTRL_IMM_BIT     = 1;
  localparam int unsigned CTRL_PENDING_BIT = 2;

  localparam int unsigned STATUS_IRQ_BIT = 31;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } csr_state_t;

endpackage

// File: rtl/video_core_csr.sv
// Avalon-MM register block with frame-synchronous shadow->active commit.
// Optional sticky commit interrupt enabled by defining VIDEO_CORE_CSR_IRQ_EN.
module video_core_csr
  import video_csr_pkg::*;
#(
  parameter int          ADDR_W    = 2,
  parameter logic [31:0] CORE_ID   = 32'h5644_0001,
  parameter logic [31:0] PARAM_RST = 32'h0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic              frame_start,
  output logic              ctrl_bypass,
  output logic [31:0]       ctrl_param,
  output logic              commit_pulse
`ifdef VIDEO_CORE_CSR_IRQ_EN
  ,
  output logic              irq
`endif
);

  csr_state_t  state_reg;
  logic        shadow_bypass_reg;
  logic        shadow_imm_reg;
  logic [31:0] shadow_param_reg;
  logic        active_bypass_reg;
  logic [31:0] active_param_reg;
  logic        commit_pulse_reg;
  logic        armed_reg;
  logic [15:0] frame_cnt_reg;
  logic [7:0]  commit_cnt_reg;
  logic [31:0] readdata_reg;
  logic        readdatavalid_reg;
  logic        irq_bit;

  logic        wr_ctrl;
  logic        wr_param;
  logic        wr_status;
  logic        wr_cfg;
  logic        commit;
  logic [31:0] read_mux;

  assign wr_ctrl   = avs_write && (avs_address == ADDR_W'(CSR_CTRL));
  assign wr_param  = avs_write && (avs_address == ADDR_W'(CSR_PARAM));
  assign wr_status = avs_write && (avs_address == ADDR_W'(CSR_STATUS));
  assign wr_cfg    = wr_ctrl || wr_param;

  // armed_reg marks that PENDING was already held on the previous cycle, so an
  // immediate commit lands on the cycle after PENDING is entered.
  assign commit = (state_reg == PENDING) &&
                  (shadow_imm_reg ? armed_reg : frame_start);

`ifdef VIDEO_CORE_CSR_IRQ_EN
  logic irq_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      irq_reg <= 1'b0;
    end else if (commit_pulse_reg) begin
      irq_reg <= 1'b1;
    end else if (wr_status && avs_writedata[STATUS_IRQ_BIT]) begin
      irq_reg <= 1'b0;
    end
  end

  assign irq     = irq_reg;
  assign irq_bit = irq_reg;
`else
  assign irq_bit = 1'b0;
`endif

  always_comb begin
    read_mux = 32'h0;
    case (avs_address)
      ADDR_W'(CSR_CTRL): begin
        read_mux[CTRL_BYPASS_BIT]  = shadow_bypass_reg;
        read_mux[CTRL_IMM_BIT]     = shadow_imm_reg;
        read_mux[CTRL_PENDING_BIT] = (state_reg == PENDING);
      end
      ADDR_W'(CSR_PARAM):  read_mux = shadow_param_reg;
      ADDR_W'(CSR_STATUS): read_mux = {irq_bit, 7'h0, commit_cnt_reg, frame_cnt_reg};
      ADDR_W'(CSR_ID):     read_mux = CORE_ID;
      default:             read_mux = 32'h0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg         <= IDLE;
      shadow_bypass_reg <= 1'b0;
      shadow_imm_reg    <= 1'b0;
      shadow_param_reg  <= PARAM_RST;
      active_bypass_reg <= 1'b0;
      active_param_reg  <= PARAM_RST;
      commit_pulse_reg  <= 1'b0;
      armed_reg         <= 1'b0;
      frame_cnt_reg     <= 16'h0;
      commit_cnt_reg    <= 8'h0;
      readdata_reg      <= 32'h0;
      readdatavalid_reg <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        shadow_bypass_reg <= avs_writedata[CTRL_BYPASS_BIT];
        shadow_imm_reg    <= avs_writedata[CTRL_IMM_BIT];
      end
      if (wr_param) begin
        shadow_param_reg <= avs_writedata;
      end

      armed_reg        <= (state_reg == PENDING);
      commit_pulse_reg <= commit;

      // Active copies the pre-write shadow; a write on the commit cycle keeps
      // the FSM in PENDING so the new value goes out at the next commit.
      if (commit) begin
        active_bypass_reg <= shadow_bypass_reg;
        active_param_reg  <= shadow_param_reg;
      end

      case (state_reg)
        IDLE:    if (wr_cfg) state_reg <= PENDING;
        PENDING: if (commit && !wr_cfg) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      if (wr_status) begin
        frame_cnt_reg <= 16'h0;
      end else if (frame_start) begin
        frame_cnt_reg <= frame_cnt_reg + 16'h1;
      end

      if (wr_status) begin
        commit_cnt_reg <= 8'h0;
      end else if (commit) begin
        commit_cnt_reg <= commit_cnt_reg + 8'h1;
      end

      readdatavalid_reg <= avs_read;
      if (avs_read) begin
        readdata_reg <= read_mux;
      end
    end
  end

  assign avs_readdata      = readdata_reg;
  assign avs_readdatavalid = readdatavalid_reg;
  assign ctrl_bypass       = active_bypass_reg;
  assign ctrl_param        = active_param_reg;
  assign commit_pulse      = commit_pulse_reg;

endmodule

// File: tb/tb_video_core_csr.sv
// Directed bench for video_core_csr: register map, frame-synchronous and
// immediate commits, counter wrap/clear and reset discard.
module tb_video_core_csr;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        frame_start;
  logic        ctrl_bypass;
  logic [31:0] ctrl_param;
  logic        commit_pulse;
`ifdef VIDEO_CORE_CSR_IRQ_EN
  logic        irq;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] rd;

  always #5 sys_clk = ~sys_clk;

  video_core_csr dut (
    .sys_clk           (sys_clk),
    .sys_rst           (sys_rst),
    .avs_address       (avs_address),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_read          (avs_read),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .frame_start       (frame_start),
    .ctrl_bypass       (ctrl_bypass),
    .ctrl_param        (ctrl_param),
    .commit_pulse      (commit_pulse)
`ifdef VIDEO_CORE_CSR_IRQ_EN
    ,
    .irq               (irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge sys_clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge sys_clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge sys_clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge sys_clk);
    avs_read = 1'b0;
    check("readdatavalid", 32'(avs_readdatavalid), 32'h1);
    d = avs_readdata;
  endtask

  task automatic pulse_frame();
    @(negedge sys_clk);
    frame_start = 1'b1;
    @(negedge sys_clk);
    frame_start = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1; avs_address = '0; avs_write = 1'b0; avs_writedata = '0;
    avs_read = 1'b0; frame_start = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;

    check("rst_param", ctrl_param, 32'h0);
    check("rst_bypass", 32'(ctrl_bypass), 32'h0);
    check("rst_commit_pulse", 32'(commit_pulse), 32'h0);
    check("rst_rvalid", 32'(avs_readdatavalid), 32'h0);

    bus_read(2'd3, rd); check("id_read", rd, 32'h5644_0001);
    @(negedge sys_clk);
    check("rvalid_one_cycle", 32'(avs_readdatavalid), 32'h0);
    bus_read(2'd0, rd); check("ctrl_rst_read", rd, 32'h0);

    // Frame-synchronous commit of PARAM
    bus_write(2'd1, 32'h0000_00AA);
    check("param_not_committed", ctrl_param, 32'h0);
    bus_read(2'd0, rd); check("ctrl_pending", rd, 32'h4);
    check("param_still_old", ctrl_param, 32'h0);
    pulse_frame();
    check("param_committed", ctrl_param, 32'h0000_00AA);
    check("commit_pulse_hi", 32'(commit_pulse), 32'h1);
    @(negedge sys_clk);
    check("commit_pulse_lo", 32'(commit_pulse), 32'h0);
    bus_read(2'd2, rd); check("status_1_1", rd, 32'h0001_0001);

    // Immediate commit: active two cycles after the write edge
    bus_write(2'd0, 32'h3);
    check("imm_bypass_t1", 32'(ctrl_bypass), 32'h0);
    @(negedge sys_clk);
    check("imm_bypass_t2_pre", 32'(ctrl_bypass), 32'h0);
    @(negedge sys_clk);
    check("imm_bypass_set", 32'(ctrl_bypass), 32'h1);
    check("imm_commit_pulse", 32'(commit_pulse), 32'h1);

    // Write colliding with frame_start while PENDING
    bus_write(2'd0, 32'h1);
    bus_write(2'd1, 32'h77);
    @(negedge sys_clk);
    avs_address = 2'd1; avs_writedata = 32'h55; avs_write = 1'b1; frame_start = 1'b1;
    @(negedge sys_clk);
    avs_write = 1'b0; frame_start = 1'b0;
    check("collide_param_old_shadow", ctrl_param, 32'h77);
    check("collide_commit_pulse", 32'(commit_pulse), 32'h1);
    bus_read(2'd0, rd); check("collide_still_pending", rd, 32'h5);
    pulse_frame();
    check("collide_param_new", ctrl_param, 32'h55);
    bus_read(2'd0, rd); check("ctrl_idle", rd, 32'h1);
    bus_read(2'd2, rd); check("status_4_3", rd, 32'h0004_0003);

    // Simultaneous read and write returns the pre-write value
    @(negedge sys_clk);
    avs_address = 2'd1; avs_writedata = 32'h1234; avs_write = 1'b1; avs_read = 1'b1;
    @(negedge sys_clk);
    avs_write = 1'b0; avs_read = 1'b0;
    check("rw_rvalid", 32'(avs_readdatavalid), 32'h1);
    check("rw_prewrite", avs_readdata, 32'h55);
    bus_read(2'd1, rd); check("param_shadow", rd, 32'h1234);
    @(negedge sys_clk);
    check("readdata_hold", avs_readdata, 32'h1234);
    check("param_active_unchanged", ctrl_param, 32'h55);
    pulse_frame();
    check("param_active_1234", ctrl_param, 32'h1234);

    bus_write(2'd3, 32'h0);
    bus_read(2'd3, rd); check("id_write_ignored", rd, 32'h5644_0001);

    // frame_cnt wrap
    bus_write(2'd2, 32'h0);
    @(negedge sys_clk);
    frame_start = 1'b1;
    repeat (65535) @(negedge sys_clk);
    frame_start = 1'b0;
    bus_read(2'd2, rd); check("frame_cnt_ffff", rd, 32'h0000_FFFF);
    pulse_frame();
    check("idle_frame_no_pulse", 32'(commit_pulse), 32'h0);
    bus_read(2'd2, rd); check("frame_cnt_wrap", rd, 32'h0);

    // STATUS clear beats a coincident frame_start
    pulse_frame();
    bus_read(2'd2, rd); check("frame_cnt_1", rd, 32'h0000_0001);
    @(negedge sys_clk);
    avs_address = 2'd2; avs_writedata = 32'h0; avs_write = 1'b1; frame_start = 1'b1;
    @(negedge sys_clk);
    avs_write = 1'b0; frame_start = 1'b0;
    bus_read(2'd2, rd); check("clear_wins", rd, 32'h0);

    // Reset while PENDING discards the update
    bus_write(2'd1, 32'h99);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("rst_mid_param", ctrl_param, 32'h0);
    check("rst_mid_bypass", 32'(ctrl_bypass), 32'h0);
    bus_read(2'd0, rd); check("rst_mid_ctrl", rd, 32'h0);
    bus_read(2'd1, rd); check("rst_mid_shadow", rd, 32'h0);
    pulse_frame();
    check("rst_mid_no_commit", 32'(commit_pulse), 32'h0);
    check("rst_mid_param_after_frame", ctrl_param, 32'h0);

`ifdef VIDEO_CORE_CSR_IRQ_EN
    check("irq_rst", 32'(irq), 32'h0);
    bus_write(2'd1, 32'h1);
    pulse_frame();
    @(negedge sys_clk);
    check("irq_set", 32'(irq), 32'h1);
    bus_write(2'd2, 32'h8000_0000);
    check("irq_cleared", 32'(irq), 32'h0);
    bus_write(2'd1, 32'h2);
    @(negedge sys_clk);
    frame_start = 1'b1;
    @(negedge sys_clk);
    frame_start = 1'b0;
    avs_address = 2'd2; avs_writedata = 32'h8000_0000; avs_write = 1'b1;
    @(negedge sys_clk);
    avs_write = 1'b0;
    check("irq_set_wins", 32'(irq), 32'h1);
    bus_read(2'd2, rd); check("irq_status_bit", rd & 32'h8000_0000, 32'h8000_0000);
    bus_write(2'd2, 32'h8000_0000);
    check("irq_later_clear", 32'(irq), 32'h0);
`else
    bus_read(2'd2, rd); check("status_bit31_zero", rd & 32'h8000_0000, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
